// File: rtl/approx_adder_pipe_if.sv
// Operand/result valid-ready bundle for approx_adder_pipe.
// The slave modport is the adder side and the master modport is the source/sink side.
interface approx_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [WIDTH:0]   out_err;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_err
  );
endinterface

// File: rtl/approx_adder_pipe.sv
// Two-stage approximate adder with a per-bit exact/approximate mask and an in-line error monitor.
// Each of the low WIDTH-1 bits is either a full adder or an OR-sum/AND-carry cell; the top bit is always exact.
module approx_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  approx_adder_pipe_if.slave bus,
  input  logic [WIDTH-2:0]   i_cfg_mask,
  input  logic               i_cfg_we,
  input  logic               i_stat_clr,
  output logic [ACC_W-1:0]   o_err_acc,
  output logic [ACC_W-1:0]   o_err_cnt,
  output logic [WIDTH:0]     o_err_max
);
  localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
  localparam logic [ACC_W-1:0] ACC_ALL = '1;

  logic [WIDTH-2:0] r_mask;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [WIDTH-2:0] r_s1_mask;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic [WIDTH:0]   r_out_err;

  logic [ACC_W-1:0] r_err_acc;
  logic [ACC_W-1:0] r_err_cnt;
  logic [WIDTH:0]   r_err_max;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_hs;
  logic [WIDTH-1:0] w_exact_bits;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH:0]   w_approx;
  logic [WIDTH:0]   w_exact;
  logic [WIDTH:0]   w_err;
  logic [SUM_W-1:0] w_acc_wide;
  logic [ACC_W-1:0] w_acc_next;
  logic [ACC_W-1:0] w_cnt_next;
  logic [WIDTH:0]   w_max_next;

  assign w_adv2 = !r_s2_valid || bus.out_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;
  assign w_hs   = r_s2_valid && bus.out_ready;

  assign bus.in_ready  = w_adv1;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_err   = r_out_err;

  assign o_err_acc = r_err_acc;
  assign o_err_cnt = r_err_cnt;
  assign o_err_max = r_err_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '1;
    end else if (i_cfg_we) begin
      r_mask <= i_cfg_mask;
    end
  end

  // The mask is captured with the operands, so a load on the accepting edge only affects later operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mask  <= '1;
    end else if (w_adv1) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_a    <= bus.in_a;
        r_s1_b    <= bus.in_b;
        r_s1_mask <= r_mask;
      end
    end
  end

  assign w_exact_bits = {1'b1, r_s1_mask};

  always_comb begin
    logic c;
    c     = 1'b0;
    w_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_exact_bits[i]) begin
        w_sum[i] = r_s1_a[i] ^ r_s1_b[i] ^ c;
        c        = (r_s1_a[i] & r_s1_b[i]) | (r_s1_a[i] & c) | (r_s1_b[i] & c);
      end else begin
        w_sum[i] = r_s1_a[i] | r_s1_b[i];
        c        = r_s1_a[i] & r_s1_b[i];
      end
    end
    w_cout = c;
  end

  assign w_approx = {w_cout, w_sum};
  assign w_exact  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_err    = (w_approx > w_exact) ? (w_approx - w_exact) : (w_exact - w_approx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
      r_out_err  <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_sum  <= w_sum;
        r_out_cout <= w_cout;
        r_out_err  <= w_err;
      end
    end
  end

  // The accumulator is widened past both operands so a single add can never wrap before the clamp.
  assign w_acc_wide = SUM_W'(r_err_acc) + SUM_W'(r_out_err);
  assign w_acc_next = (w_acc_wide > SUM_W'(ACC_ALL)) ? ACC_ALL : w_acc_wide[ACC_W-1:0];
  assign w_cnt_next = ((r_out_err != '0) && (r_err_cnt != ACC_ALL)) ? (r_err_cnt + ACC_W'(1))
                                                                     : r_err_cnt;
  assign w_max_next = (r_out_err > r_err_max) ? r_out_err : r_err_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_acc <= '0;
      r_err_cnt <= '0;
      r_err_max <= '0;
    end else if (i_stat_clr) begin
      r_err_acc <= '0;
      r_err_cnt <= '0;
      r_err_max <= '0;
    end else if (w_hs) begin
      r_err_acc <= w_acc_next;
      r_err_cnt <= w_cnt_next;
      r_err_max <= w_max_next;
    end
  end
endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed bench for approx_adder_pipe: a bit-serial arithmetic model plus a result queue,
// checked every cycle, with literal expectations that pin the model, and a small-accumulator saturation instance.
module tb_approx_adder_pipe;
  localparam int WIDTH = 16;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic [16:0] err;
    int          readyCyc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  approx_adder_pipe_if #(.WIDTH(WIDTH)) bus ();
  approx_adder_pipe_if #(.WIDTH(WIDTH)) satBus ();

  logic [WIDTH-2:0] cfgMask, satCfgMask;
  logic             cfgWe, satCfgWe, statClr, satStatClr;
  logic [31:0]      errAcc, errCnt;
  logic [3:0]       satErrAcc, satErrCnt;
  logic [WIDTH:0]   errMax, satErrMax;

  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  res_t    expQ[$];
  logic [14:0] modelMask;
  longint  mAcc, mCnt;
  logic [16:0] mMax;
  bit      sawStall = 1'b0;
  bit      monHs;
  bit      monExpValid;
  res_t    monRes;
  res_t    pinRes;

  approx_adder_pipe #(.WIDTH(WIDTH), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .i_cfg_mask(cfgMask), .i_cfg_we(cfgWe), .i_stat_clr(statClr),
    .o_err_acc(errAcc), .o_err_cnt(errCnt), .o_err_max(errMax)
  );

  approx_adder_pipe #(.WIDTH(WIDTH), .ACC_W(4)) dutSat (
    .clk(clk), .rst_n(rst_n), .bus(satBus),
    .i_cfg_mask(satCfgMask), .i_cfg_we(satCfgWe), .i_stat_clr(satStatClr),
    .o_err_acc(satErrAcc), .o_err_cnt(satErrCnt), .o_err_max(satErrMax)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Walk the bits with an integer carry: exact bits add, approximate bits OR and emit their own AND as carry.
  function automatic res_t modelAdd(input logic [15:0] a, input logic [15:0] b, input logic [14:0] m);
    res_t r;
    logic [15:0] ex;
    int c, s, ai, bi, approxVal, exactVal;
    ex = {1'b1, m};
    c = 0;
    r.sum = '0;
    for (int i = 0; i < 16; i++) begin
      ai = int'(a[i]);
      bi = int'(b[i]);
      if (ex[i]) begin
        s = ai + bi + c;
        r.sum[i] = (s % 2) != 0;
        c = s / 2;
      end else begin
        r.sum[i] = (ai | bi) != 0;
        c = ai & bi;
      end
    end
    r.cout = (c != 0);
    approxVal = c * 65536 + int'(r.sum);
    exactVal = int'(a) + int'(b);
    r.err = 17'((approxVal > exactVal) ? approxVal - exactVal : exactVal - approxVal);
    r.readyCyc = 0;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Every negedge: compare against the model state, then predict what the coming edge does.
  // A pair accepted on edge E+1 is registered into the output on edge E+2.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      expQ.delete();
      modelMask = '1;
      mAcc = 0;
      mCnt = 0;
      mMax = '0;
      checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    end else begin
      if (!bus.in_ready) sawStall = 1'b1;
      checkOutput("in_ready", 64'(bus.in_ready), 64'(!(expQ.size() == 2 && !bus.out_ready)));
      monExpValid = (expQ.size() > 0) && (cyc >= expQ[0].readyCyc);
      checkOutput("out_valid", 64'(bus.out_valid), 64'(monExpValid));
      if (bus.out_valid && expQ.size() > 0) begin
        checkOutput("out_sum", 64'(bus.out_sum), 64'(expQ[0].sum));
        checkOutput("out_cout", 64'(bus.out_cout), 64'(expQ[0].cout));
        checkOutput("out_err", 64'(bus.out_err), 64'(expQ[0].err));
      end
      checkOutput("err_acc", 64'(errAcc), 64'(mAcc));
      checkOutput("err_cnt", 64'(errCnt), 64'(mCnt));
      checkOutput("err_max", 64'(errMax), 64'(mMax));

      monHs = bus.out_valid && bus.out_ready && (expQ.size() > 0);
      if (monHs) monRes = expQ.pop_front();
      if (statClr) begin
        mAcc = 0;
        mCnt = 0;
        mMax = '0;
      end else if (monHs) begin
        mAcc = mAcc + longint'(monRes.err);
        if (mAcc > 64'hFFFF_FFFF) mAcc = 64'hFFFF_FFFF;
        if (monRes.err != 0 && mCnt < 64'hFFFF_FFFF) mCnt = mCnt + 1;
        if (monRes.err > mMax) mMax = monRes.err;
      end
      if (bus.in_valid && bus.in_ready) begin
        monRes = modelAdd(bus.in_a, bus.in_b, modelMask);
        monRes.readyCyc = cyc + 2;
        expQ.push_back(monRes);
      end
      if (cfgWe) modelMask = cfgMask;
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    bit accepted;
    accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("[TB] FAIL accept timeout: got no in_ready expected accept within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setMask(input logic [14:0] m);
    cfgMask = m;
    cfgWe = 1'b1;
    @(posedge clk);
    #1;
    cfgWe = 1'b0;
  endtask

  task automatic expectResult(input string name, input logic [15:0] sum, input logic cout,
                              input logic [16:0] err);
    bit seen;
    seen = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout: got no out_valid expected a result", name);
    end else begin
      checkOutput({name, " sum"}, 64'(bus.out_sum), 64'(sum));
      checkOutput({name, " cout"}, 64'(bus.out_cout), 64'(cout));
      checkOutput({name, " err"}, 64'(bus.out_err), 64'(err));
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] streamA[10] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h8001, 16'h0F0F,
                               16'hAAAA, 16'h5555, 16'h7FFF, 16'h0001, 16'hC3C3};
  logic [15:0] streamB[10] = '{16'h4321, 16'h0001, 16'h0F01, 16'h7FFF, 16'hF0F0,
                               16'h5555, 16'h5555, 16'h0001, 16'hFFFF, 16'h3C3C};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    satBus.in_valid = 1'b0; satBus.in_a = '0; satBus.in_b = '0; satBus.out_ready = 1'b1;
    cfgMask = '1; cfgWe = 1'b0; statClr = 1'b0;
    satCfgMask = '1; satCfgWe = 1'b0; satStatClr = 1'b0;

    pinRes = modelAdd(16'h000A, 16'h000C, 15'h7FFF);
    checkOutput("pin exact sum", 64'(pinRes.sum), 64'h0016);
    checkOutput("pin exact err", 64'(pinRes.err), 64'd0);
    pinRes = modelAdd(16'h000A, 16'h000C, 15'h7FF0);
    checkOutput("pin low4 sum", 64'(pinRes.sum), 64'h001E);
    checkOutput("pin low4 err", 64'(pinRes.err), 64'd8);
    pinRes = modelAdd(16'hFFFF, 16'h0001, 15'h7FFF);
    checkOutput("pin wrap sum", 64'(pinRes.sum), 64'h0000);
    checkOutput("pin wrap cout", 64'(pinRes.cout), 64'd1);
    pinRes = modelAdd(16'h000F, 16'h0001, 15'h0000);
    checkOutput("pin allapprox sum", 64'(pinRes.sum), 64'h000F);
    checkOutput("pin allapprox err", 64'(pinRes.err), 64'd1);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset out_valid lit", 64'(bus.out_valid), 64'd0);
    checkOutput("reset out_sum", 64'(bus.out_sum), 64'd0);
    checkOutput("reset out_err", 64'(bus.out_err), 64'd0);
    checkOutput("reset err_acc lit", 64'(errAcc), 64'd0);
    @(posedge clk);
    #1;

    applyStimulus(16'h000A, 16'h000C);
    expectResult("exact", 16'h0016, 1'b0, 17'd0);
    checkOutput("exact err_cnt", 64'(errCnt), 64'd0);

    setMask(15'h7FF0);
    applyStimulus(16'h000A, 16'h000C);
    expectResult("low4 approx", 16'h001E, 1'b0, 17'd8);
    checkOutput("low4 err_acc", 64'(errAcc), 64'd8);
    checkOutput("low4 err_cnt", 64'(errCnt), 64'd1);
    checkOutput("low4 err_max", 64'(errMax), 64'd8);

    setMask(15'h7FFF);
    applyStimulus(16'hFFFF, 16'h0001);
    expectResult("wrap", 16'h0000, 1'b1, 17'd0);

    setMask(15'h7F0F);
    fork
      begin
        for (int i = 0; i < 10; i++) applyStimulus(streamA[i], streamB[i]);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
      end
    join
    idle(6);
    checkOutput("stall in_ready dropped", 64'(sawStall), 64'd1);
    checkOutput("stream drained", 64'(expQ.size()), 64'd0);

    setMask(15'h7FFF);
    cfgMask = 15'h0000;
    cfgWe = 1'b1;
    applyStimulus(16'h000F, 16'h0001);
    cfgWe = 1'b0;
    expectResult("old mask", 16'h0010, 1'b0, 17'd0);
    applyStimulus(16'h000F, 16'h0001);
    expectResult("new mask", 16'h000F, 1'b0, 17'd1);

    applyStimulus(16'h000F, 16'h0001);
    bus.in_valid = 1'b0;
    statClr = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    statClr = 1'b0;
    idle(2);
    checkOutput("clear err_acc", 64'(errAcc), 64'd0);
    checkOutput("clear err_cnt", 64'(errCnt), 64'd0);
    checkOutput("clear err_max", 64'(errMax), 64'd0);

    applyStimulus(16'h000F, 16'h0001);
    expectResult("pre-reset", 16'h000F, 1'b0, 17'd1);
    checkOutput("pre-reset err_acc", 64'(errAcc), 64'd1);
    setMask(15'h1234);
    bus.out_ready = 1'b0;
    applyStimulus(16'h0003, 16'h0005);
    applyStimulus(16'h0007, 16'h0009);
    bus.in_valid = 1'b0;
    checkOutput("inflight out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async reset err_acc", 64'(errAcc), 64'd0);
    checkOutput("async reset err_max", 64'(errMax), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("no stale output", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(16'h000F, 16'h0001);
    expectResult("post-reset mask", 16'h0010, 1'b0, 17'd0);
    checkOutput("post-reset err_cnt", 64'(errCnt), 64'd0);

    satCfgMask = 15'h7FFE;
    satCfgWe = 1'b1;
    @(posedge clk);
    #1;
    satCfgWe = 1'b0;
    satBus.in_valid = 1'b1;
    satBus.in_a = 16'h0001;
    satBus.in_b = 16'h0001;
    repeat (20) begin @(posedge clk); #1; end
    satBus.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("sat err_acc", 64'(satErrAcc), 64'd15);
    checkOutput("sat err_cnt", 64'(satErrCnt), 64'd15);
    checkOutput("sat err_max", 64'(satErrMax), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
